// File: rtl/e_mdu_multicycle_if.sv
// Handshake and result bundle between the E stage and the multi-cycle MDU.
// The E stage is the master; the MDU is the slave.
interface e_mdu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/e_mdu_multicycle.sv
// Multi-cycle multiply/divide unit with HI/LO. The result is computed at accept
// into a shadow and committed to HI/LO only when the busy countdown expires.
module e_mdu_multicycle #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    e_mdu_multicycle_if.slave  mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] shadow_hi_reg;
    logic [WIDTH-1:0] shadow_lo_reg;
    logic             commit_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic             busy;
    logic             accept;
    logic             is_unsigned;
    logic [2*WIDTH-1:0] prod;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] div_num;
    logic [WIDTH-1:0] div_den;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    assign busy        = (cnt_reg != '0);
    assign accept      = mdu.start && !busy;
    // op[0] selects the unsigned flavour for both MULTU and DIVU.
    assign is_unsigned = mdu.op[0];

    assign prod = is_unsigned
                ? ({{WIDTH{1'b0}}, mdu.a} * {{WIDTH{1'b0}}, mdu.b})
                : ({{WIDTH{mdu.a[WIDTH-1]}}, mdu.a} * {{WIDTH{mdu.b[WIDTH-1]}}, mdu.b});

    // Signed division runs on magnitudes; MIN's magnitude is representable unsigned,
    // so MIN/-1 falls out as quotient MIN, remainder 0 without special casing.
    assign a_neg   = !is_unsigned && mdu.a[WIDTH-1];
    assign b_neg   = !is_unsigned && mdu.b[WIDTH-1];
    assign a_mag   = a_neg ? (~mdu.a + 1'b1) : mdu.a;
    assign b_mag   = b_neg ? (~mdu.b + 1'b1) : mdu.b;
    assign div_num = a_mag;
    // A zero divisor is replaced so the shadow never holds undefined data.
    assign div_den = (mdu.b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag   = div_num / div_den;
    assign r_mag   = div_num % div_den;
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 1'b1) : r_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            shadow_hi_reg <= '0;
            shadow_lo_reg <= '0;
            commit_reg    <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                case (mdu.op)
                    OP_MULT, OP_MULTU: begin
                        shadow_hi_reg <= prod[2*WIDTH-1:WIDTH];
                        shadow_lo_reg <= prod[WIDTH-1:0];
                        commit_reg    <= 1'b1;
                        cnt_reg       <= CNT_W'(MULT_CYCLES);
                    end
                    OP_DIV, OP_DIVU: begin
                        shadow_hi_reg <= rem;
                        shadow_lo_reg <= quot;
                        commit_reg    <= (mdu.b != '0);
                        cnt_reg       <= CNT_W'(DIV_CYCLES);
                    end
                    OP_MTHI: hi_reg <= mdu.a;
                    OP_MTLO: lo_reg <= mdu.a;
                    default: ;
                endcase
            end else if (busy) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    done_reg <= 1'b1;
                    if (commit_reg) begin
                        hi_reg <= shadow_hi_reg;
                        lo_reg <= shadow_lo_reg;
                    end
                end
            end
        end
    end

    assign mdu.busy = busy;
    assign mdu.done = done_reg;
    assign mdu.hi   = hi_reg;
    assign mdu.lo   = lo_reg;
endmodule

// File: tb/tb_e_mdu_multicycle.sv
// Randomised and directed bench for e_mdu_multicycle against a transaction-level
// arithmetic model; exercises a default instance and a 1-cycle instance.
module tb_e_mdu_multicycle;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_multicycle_if #(.WIDTH(W)) if0 ();
    e_mdu_multicycle_if #(.WIDTH(W)) if1 ();

    logic         start;
    logic         sel;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    assign if0.start = start & ~sel;
    assign if1.start = start & sel;
    assign if0.op = op;
    assign if1.op = op;
    assign if0.a  = a;
    assign if1.a  = a;
    assign if0.b  = b;
    assign if1.b  = b;

    wire         busy_s = sel ? if1.busy : if0.busy;
    wire         done_s = sel ? if1.done : if0.done;
    wire [W-1:0] hi_s   = sel ? if1.hi   : if0.hi;
    wire [W-1:0] lo_s   = sel ? if1.lo   : if0.lo;

    e_mdu_multicycle #(.WIDTH(W)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .mdu   (if0)
    );

    e_mdu_multicycle #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .mdu   (if1)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] m_hi [2];
    logic [W-1:0] m_lo [2];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic using 64-bit integers.
    task automatic ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] h_in, input logic [W-1:0] l_in,
                             output logic [W-1:0] h, output logic [W-1:0] l);
        longint sx, sy, p, q, r;
        longint unsigned ux, uy, up;
        h = h_in;
        l = l_in;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            3'd1: begin up = ux * uy; h = up[63:32]; l = up[31:0]; end
            3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
            3'd3: if (y != 0) begin h = x % y; l = x / y; end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endtask

    // Issue one op at the current negedge (busy must be low) and follow it to completion.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit junk);
        int n;
        int s;
        int need;
        logic [W-1:0] eh, el;
        s = sel ? 1 : 0;
        ref_model(o, x, y, m_hi[s], m_lo[s], eh, el);
        if (o <= 3'd1)      need = s ? 1 : 5;
        else if (o <= 3'd3) need = s ? 1 : 10;
        else                need = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy_s && n < 200) begin
            check_val("done_while_busy", {63'd0, done_s}, 64'd0);
            check_val("hi_hold", {32'd0, hi_s}, {32'd0, m_hi[s]});
            if (junk) begin
                start = 1'b1;
                op = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b100;
                a = $urandom;
                b = $urandom;
            end
            n++;
            @(negedge clk);
            start = 1'b0;
        end
        check_val("busy_cycles", 64'(n), 64'(need));
        check_val("done", {63'd0, done_s}, (need != 0) ? 64'd1 : 64'd0);
        m_hi[s] = eh;
        m_lo[s] = el;
        check_val("hi", {32'd0, hi_s}, {32'd0, eh});
        check_val("lo", {32'd0, lo_s}, {32'd0, el});
        $display("dut%0d op=%0d a=%h b=%h junk=%0d busy=%0d hi=%h lo=%h", s, o, x, y, junk, n, hi_s, lo_s);
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; op = '0; a = '0; b = '0;
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {63'd0, busy_s}, 64'd0);
        check_val("rst_done", {63'd0, done_s}, 64'd0);
        check_val("rst_hi", {32'd0, hi_s}, 64'd0);
        check_val("rst_lo", {32'd0, lo_s}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_val("mult_neg_hi", {32'd0, hi_s}, 64'hFFFF_FFFF);
        check_val("mult_neg_lo", {32'd0, lo_s}, 64'hFFFF_FFFA);
        @(negedge clk);
        check_val("done_one_pulse", {63'd0, done_s}, 64'd0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_val("div_neg_lo", {32'd0, lo_s}, 64'hFFFF_FFFD);
        do_op(3'd3, 32'd7, 32'd0, 1'b0);
        check_val("divz_hi", {32'd0, hi_s}, 64'hFFFF_FFFF);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd0, 32'd1234, 32'd5678, 1'b1);
        do_op(3'd4, 32'h0000_1234, 32'd0, 1'b0);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
        do_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);

        // Asynchronous reset on the third busy cycle of a DIV.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("arst_busy", {63'd0, busy_s}, 64'd0);
        check_val("arst_hi", {32'd0, hi_s}, 64'd0);
        check_val("arst_lo", {32'd0, lo_s}, 64'd0);
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check_val("arst_no_commit_hi", {32'd0, hi_s}, 64'd0);
        check_val("arst_no_commit_lo", {32'd0, lo_s}, 64'd0);

        // Back-to-back: MULT issued in the DIV's done cycle.
        do_op(3'd2, 32'd100, 32'd7, 1'b0);
        do_op(3'd0, 32'hFFFF_FFF0, 32'd16, 1'b0);

        for (int i = 0; i < 50; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        sel = 1'b1;
        @(negedge clk);
        do_op(3'd2, 32'd100, 32'd7, 1'b0);
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        do_op(3'd3, 32'd9, 32'd0, 1'b1);
        do_op(3'd4, 32'h0000_ABCD, 32'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
